// File: rtl/vga_ram_ctrl_pkg.sv
// Shared types for the VGA RAM port controller.
// Optional VGA_FAIR_ARB_EN selects alternating arbitration.
package vga_ctrl_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CRD,
        CWAIT,
        CWR,
        FIN
    } eng_state_t;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

endpackage

// File: rtl/vga_ram_ctrl_if.sv
// CPU-side bus of the VGA RAM port controller.
// master = CPU decoder, slave = controller.
interface vga_ram_ctrl_if #(
    parameter int AW = 12,
    parameter int DW = 8
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_din;
    logic          cpu_gnt;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_din,
        input  cpu_gnt, cpu_ack, cpu_dout
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_din,
        output cpu_gnt, cpu_ack, cpu_dout
    );

endinterface

// File: rtl/vga_ram_arb.sv
// Two-requester RAM port arbiter, CPU first by default.
// VGA_FAIR_ARB_EN: alternate the winner on contested cycles.
module vga_ram_arb (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic eng_req,
    output logic cpu_gnt,
    output logic eng_gnt
);

`ifdef VGA_FAIR_ARB_EN
    localparam logic FAIR = 1'b1;
`else
    localparam logic FAIR = 1'b0;
`endif

    logic contest;
    logic eng_turn;

    assign contest = cpu_req & eng_req;
    assign cpu_gnt = cpu_req & ~(contest & FAIR & eng_turn);
    assign eng_gnt = eng_req & ~cpu_gnt;

    // Engine gets the next contested cycle after the CPU wins one
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            eng_turn <= 1'b0;
        end else if (contest) begin
            eng_turn <= cpu_gnt;
        end
    end

endmodule

// File: rtl/vga_ram_ctrl.sv
// VGA char/attr RAM A-port controller: CPU access plus fill/copy engine.
// Define VGA_FAIR_ARB_EN for alternating CPU/engine arbitration.
module vga_ram_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    vga_ram_ctrl_if.slave cpu,
    input  logic          cmd_start,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW:0]   cmd_len,
    input  logic [DW-1:0] cmd_fill,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    eng_state_t    state, state_nx;
    logic          dec_q;
    logic [AW:0]   len_q;
    logic [AW-1:0] src_q, dst_q;
    logic [DW-1:0] fill_q, buf_q;

    logic          eng_req, eng_we;
    logic [AW-1:0] eng_a;
    logic [DW-1:0] eng_din;
    logic          cpu_gnt, eng_gnt;

    logic          launch, launch_dec, last;
    logic [AW-1:0] off, step;

    assign launch     = (state == IDLE) && cmd_start;
    assign launch_dec = (cmd_op == OP_COPY) && (cmd_dst > cmd_src);
    assign off        = cmd_len[AW-1:0] - AW'(1);
    // All-ones is -1 modulo 2^AW
    assign step       = dec_q ? {AW{1'b1}} : AW'(1);
    assign last       = (len_q == (AW+1)'(1));

    vga_ram_arb u_arb (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .cpu_req (cpu.cpu_req),
        .eng_req (eng_req),
        .cpu_gnt (cpu_gnt),
        .eng_gnt (eng_gnt)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_len == '0)
                        state_nx = FIN;
                    else if (cmd_op == OP_COPY)
                        state_nx = CRD;
                    else
                        state_nx = FILL;
                end
            end
            FILL:  if (eng_gnt && last) state_nx = FIN;
            CRD:   if (eng_gnt) state_nx = CWAIT;
            CWAIT: state_nx = CWR;
            CWR:   if (eng_gnt) state_nx = last ? FIN : CRD;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        eng_req = 1'b0;
        eng_we  = 1'b0;
        eng_a   = '0;
        eng_din = '0;
        unique case (state)
            FILL: begin
                eng_req = 1'b1;
                eng_we  = 1'b1;
                eng_a   = dst_q;
                eng_din = fill_q;
            end
            CRD: begin
                eng_req = 1'b1;
                eng_a   = src_q;
            end
            CWR: begin
                eng_req = 1'b1;
                eng_we  = 1'b1;
                eng_a   = dst_q;
                eng_din = buf_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dec_q  <= 1'b0;
            len_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            fill_q <= '0;
            buf_q  <= '0;
        end else begin
            if (launch) begin
                dec_q  <= launch_dec;
                len_q  <= cmd_len;
                fill_q <= cmd_fill;
                src_q  <= launch_dec ? cmd_src + off : cmd_src;
                dst_q  <= launch_dec ? cmd_dst + off : cmd_dst;
            end else if (eng_gnt && eng_we) begin
                dst_q <= dst_q + step;
                len_q <= len_q - (AW+1)'(1);
                if (state == CWR)
                    src_q <= src_q + step;
            end
            if (state == CWAIT)
                buf_q <= ram_dout;
        end
    end

    always_comb begin
        ram_a   = '0;
        ram_we  = 1'b0;
        ram_din = '0;
        unique case (1'b1)
            cpu_gnt: begin
                ram_a   = cpu.cpu_a;
                ram_we  = cpu.cpu_we;
                ram_din = cpu.cpu_din;
            end
            eng_gnt: begin
                ram_a   = eng_a;
                ram_we  = eng_we;
                ram_din = eng_din;
            end
            default: ;
        endcase
    end

    assign cpu.cpu_gnt  = cpu_gnt;
    assign cpu.cpu_dout = ram_dout;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cpu.cpu_ack <= 1'b0;
        end else begin
            cpu.cpu_ack <= cpu_gnt;
        end
    end

endmodule

// File: tb/tb_vga_ram_ctrl.sv
// Directed bench for vga_ram_ctrl with a behavioural 4 KiB sync RAM.
// Contention expectations follow VGA_FAIR_ARB_EN when defined.
module tb_vga_ram_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_op = 1'b0;
    logic [11:0] cmd_src = '0;
    logic [11:0] cmd_dst = '0;
    logic [12:0] cmd_len = '0;
    logic [7:0]  cmd_fill = '0;
    logic        busy, done;
    logic [11:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;

    int vectors = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic [7:0] orig [0:4095];
    logic       pl_go = 1'b0;
    logic [7:0] pl_seed = '0;
    int         wr_cnt = 0;

    vga_ram_ctrl_if #(.AW(12), .DW(8)) cpu_bus ();

    vga_ram_ctrl #(.AW(12), .DW(8)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .cpu       (cpu_bus),
        .cmd_start (cmd_start),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done),
        .ram_a     (ram_a),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] pat(input int i, input logic [7:0] s);
        return 8'(i * 13 + (i >> 4)) ^ s;
    endfunction

    always @(posedge clk_sys) begin
        if (pl_go) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i, pl_seed);
        end else if (ram_we) begin
            mem[ram_a] <= ram_din;
            wr_cnt <= wr_cnt + 1;
        end
        ram_dout <= mem[ram_a];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic preload(input logic [7:0] s);
        pl_seed = s;
        pl_go = 1'b1;
        tick();
        pl_go = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i, s);
    endtask

    function automatic int count_bad(output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic launch(input logic op, input logic [11:0] src,
                          input logic [11:0] dst, input logic [12:0] len,
                          input logic [7:0] fill);
        cmd_op = op;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_fill = fill;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // n = index of the FIN cycle, first cycle after launch is 1; -1 on timeout
    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!done && n <= limit) begin
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy, done, cpu_bus.cpu_ack, cpu_bus.cpu_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/ack/gnt=%b want 0000",
                     {busy, done, cpu_bus.cpu_ack, cpu_bus.cpu_gnt});
        end
        vectors++;
        if ({ram_we, ram_a, ram_din} !== 21'd0) begin
            errors++;
            $display("FAIL reset_port: we=%b a=%03h din=%02h want 0",
                     ram_we, ram_a, ram_din);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_rw();
        cpu_bus.cpu_req = 1'b1;
        cpu_bus.cpu_we = 1'b1;
        cpu_bus.cpu_a = 12'h123;
        cpu_bus.cpu_din = 8'h5A;
        #1;
        vectors++;
        if ({cpu_bus.cpu_gnt, ram_we, ram_a, ram_din} !== {2'b11, 12'h123, 8'h5A}) begin
            errors++;
            $display("FAIL cpu_wr_gnt: gnt=%b we=%b a=%03h din=%02h want 1 1 123 5a",
                     cpu_bus.cpu_gnt, ram_we, ram_a, ram_din);
        end
        tick();
        cpu_bus.cpu_we = 1'b0;
        #1;
        vectors++;
        if ({cpu_bus.cpu_ack, cpu_bus.cpu_gnt, ram_we} !== 3'b110) begin
            errors++;
            $display("FAIL cpu_b2b: ack/gnt/we=%b want 110",
                     {cpu_bus.cpu_ack, cpu_bus.cpu_gnt, ram_we});
        end
        tick();
        cpu_bus.cpu_req = 1'b0;
        vectors++;
        if (cpu_bus.cpu_ack !== 1'b1 || cpu_bus.cpu_dout !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_rd: ack=%b dout=%02h want 1 5a",
                     cpu_bus.cpu_ack, cpu_bus.cpu_dout);
        end
        #1;
        vectors++;
        if ({cpu_bus.cpu_gnt, ram_we, ram_a} !== 14'd0) begin
            errors++;
            $display("FAIL cpu_idle: gnt=%b we=%b a=%03h want 0 0 000",
                     cpu_bus.cpu_gnt, ram_we, ram_a);
        end
        tick();
        vectors++;
        if (cpu_bus.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_ack_drop: ack=%b want 0", cpu_bus.cpu_ack);
        end
    endtask

    task automatic test_fill_wrap();
        int n, bad, first;
        preload(8'h11);
        launch(1'b0, 12'h000, 12'hFF0, 13'd32, 8'h20);
        wait_done(100, n);
        vectors++;
        if (n + 1 !== 34) begin
            errors++;
            $display("FAIL fill_cycles: start..done=%0d want 34", n + 1);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL fill_end: busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < 32; i++) ref_mem[(12'hFF0 + i) & 12'hFFF] = 8'h20;
        bad = count_bad(first);
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fill_mem: %0d bad, first %03h got %02h want %02h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_len_zero();
        int n, snap;
        snap = wr_cnt;
        launch(1'b0, 12'h000, 12'h010, 13'd0, 8'hFF);
        wait_done(10, n);
        vectors++;
        if (n !== 1 || wr_cnt !== snap) begin
            errors++;
            $display("FAIL len_zero: fin_at=%0d writes=%0d want 1 0",
                     n, wr_cnt - snap);
        end
        tick();
    endtask

    task automatic test_copy_up();
        int n, bad, first;
        preload(8'h3C);
        orig = ref_mem;
        launch(1'b1, 12'h050, 12'h000, 13'hF50, 8'h00);
        wait_done(12000, n);
        vectors++;
        if (n !== 3 * 13'hF50 + 1) begin
            errors++;
            $display("FAIL copy_up_cycles: fin_at=%0d want %0d", n, 3 * 13'hF50 + 1);
        end
        tick();
        for (int i = 0; i < 13'hF50; i++) ref_mem[i] = orig[i + 12'h050];
        bad = count_bad(first);
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL copy_up_mem: %0d bad, first %03h got %02h want %02h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_copy_overlap();
        int n, bad, first;
        preload(8'hA7);
        orig = ref_mem;
        launch(1'b1, 12'h000, 12'h050, 13'h100, 8'h00);
        vectors++;
        if (ram_a !== 12'h0FF || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL copy_dn_first: a=%03h we=%b want 0ff 0", ram_a, ram_we);
        end
        wait_done(1000, n);
        vectors++;
        if (n !== 3 * 256 + 1) begin
            errors++;
            $display("FAIL copy_dn_cycles: fin_at=%0d want %0d", n, 3 * 256 + 1);
        end
        tick();
        for (int i = 0; i < 256; i++) ref_mem[12'h050 + i] = orig[i];
        bad = count_bad(first);
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL copy_dn_mem: %0d bad, first %03h got %02h want %02h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_contention();
        int n, bad, first;
        preload(8'h55);
        cpu_bus.cpu_req = 1'b1;
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_a = 12'h200;
        launch(1'b0, 12'h000, 12'h600, 13'd4, 8'hEE);
`ifdef VGA_FAIR_ARB_EN
        wait_done(10, n);
        vectors++;
        if (n < 1 || n > 10) begin
            errors++;
            $display("FAIL fair_done: fin_at=%0d want 1..10", n);
        end
        cpu_bus.cpu_req = 1'b0;
        tick();
`else
        begin
            int dn = 0;
            for (int i = 0; i < 20; i++) begin
                if (done) dn++;
                tick();
            end
            vectors++;
            if (busy !== 1'b1 || dn !== 0) begin
                errors++;
                $display("FAIL starve: busy=%b dones=%0d want 1 0", busy, dn);
            end
            bad = count_bad(first);
            vectors++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL starve_mem: %0d bytes written want 0", bad);
            end
        end
        cpu_bus.cpu_req = 1'b0;
        wait_done(20, n);
        vectors++;
        if (n !== 5) begin
            errors++;
            $display("FAIL release_done: fin_at=%0d want 5", n);
        end
        tick();
`endif
        for (int i = 0; i < 4; i++) ref_mem[12'h600 + i] = 8'hEE;
        bad = count_bad(first);
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL contend_mem: %0d bad, first %03h got %02h want %02h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_reset_mid_copy();
        int snap;
        int dn = 0;
        launch(1'b1, 12'h300, 12'h400, 13'd16, 8'h00);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        snap = wr_cnt;
        vectors++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: busy=%b we=%b want 0 0", busy, ram_we);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done) dn++;
            tick();
        end
        vectors++;
        if (dn !== 0 || wr_cnt !== snap || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: dones=%0d writes=%0d busy=%b want 0 0 0",
                     dn, wr_cnt - snap, busy);
        end
    endtask

    task automatic test_start_in_fin();
        int n, bad, first;
        preload(8'h01);
        launch(1'b0, 12'h000, 12'h700, 13'd1, 8'hAA);
        tick();
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL fin_cycle: done=%b want 1", done);
        end
        launch(1'b0, 12'h000, 12'h702, 13'd1, 8'hCC);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fin_ignore: busy=%b want 0", busy);
        end
        launch(1'b0, 12'h000, 12'h703, 13'd1, 8'hDD);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL after_fin_accept: busy=%b want 1", busy);
        end
        wait_done(5, n);
        vectors++;
        if (n !== 2) begin
            errors++;
            $display("FAIL after_fin_done: fin_at=%0d want 2", n);
        end
        tick();
        ref_mem[12'h700] = 8'hAA;
        ref_mem[12'h703] = 8'hDD;
        bad = count_bad(first);
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fin_mem: %0d bad, first %03h got %02h want %02h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    initial begin
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_a = '0;
        cpu_bus.cpu_din = '0;
        test_reset();
        test_cpu_rw();
        test_fill_wrap();
        test_len_zero();
        test_copy_up();
        test_copy_overlap();
        test_contention();
        test_reset_mid_copy();
        test_start_in_fin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
